// File: rtl/ram_burst_reader.sv
// rtl/ram_burst_reader.sv - burst read initiator for a registered-read RAM port; optional abort via RAM_BURST_ABORT_EN
module ram_burst_reader #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8,
    parameter int OUT_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_len_m1,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_data,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
`ifdef RAM_BURST_ABORT_EN
    input  logic                  abort,
    output logic                  aborted,
`endif
    output logic                  done
);

    localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CW = $clog2(OUT_DEPTH + 1);
    localparam int BW = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   next_addr;
    logic [ADDR_WIDTH-1:0]   ram_addr_q;
    logic [BW-1:0]           beats_left;
    logic                    inflight;
    logic                    inflight_last;
    logic [DATA_WIDTH-1:0]   buf_data [OUT_DEPTH];
    logic                    buf_last [OUT_DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [CW-1:0]           count;
    logic                    pop;
    logic                    issue;
    logic                    kill;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef RAM_BURST_ABORT_EN
    assign kill    = abort & (state != IDLE);
    assign aborted = kill;
`else
    assign kill    = 1'b0;
`endif

    assign pop = out_valid & out_ready;

    // Reserve a slot for the read still in flight so the buffer can never overflow.
    assign issue = (state == ISSUE) && !kill &&
                   (int'(count) + int'(inflight) - int'(pop) + 1 <= OUT_DEPTH);

    assign ram_addr  = issue ? next_addr : ram_addr_q;
    assign ram_we    = 1'b0;
    assign ram_data  = '0;
    assign out_valid = (count != '0);
    assign out_data  = buf_data[rd_ptr];
    assign out_last  = out_valid & buf_last[rd_ptr];
    assign busy      = (state != IDLE);
    assign cmd_ready = (state == IDLE);
    assign done      = pop & out_last & !kill;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            next_addr     <= '0;
            ram_addr_q    <= '0;
            beats_left    <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                buf_data[i] <= '0;
                buf_last[i] <= 1'b0;
            end
        end else if (kill) begin
            state    <= IDLE;
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        next_addr  <= cmd_addr;
                        beats_left <= {1'b0, cmd_len_m1} + BW'(1);
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        next_addr  <= next_addr + 1'b1;
                        ram_addr_q <= next_addr;
                        beats_left <= beats_left - BW'(1);
                        if (beats_left == BW'(1))
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && out_last)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            inflight      <= issue;
            inflight_last <= issue && (beats_left == BW'(1));

            // RAM data for last cycle's issue arrives now.
            if (inflight) begin
                buf_data[wr_ptr] <= ram_q;
                buf_last[wr_ptr] <= inflight_last;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(inflight) - CW'(pop);
        end
    end

endmodule
